// File: rtl/regfile_read_unit_if.sv
// Bus between the write decoder / decode stage and the register file read unit.
// The slave side is the register file; the master side drives writes and read requests.
interface regfile_read_unit_if #(
    parameter int WIDTH = 16
);
    logic [15:0]      Wordline;
    logic [WIDTH-1:0] WriteData;
    logic [3:0]       SrcReg1;
    logic             ReadEn1;
    logic [3:0]       SrcReg2;
    logic             ReadEn2;
    logic [WIDTH-1:0] SrcData1;
    logic             RdValid1;
    logic [WIDTH-1:0] SrcData2;
    logic             RdValid2;
    logic             WlErr;

    modport master (
        output Wordline, WriteData, SrcReg1, ReadEn1, SrcReg2, ReadEn2,
        input  SrcData1, RdValid1, SrcData2, RdValid2, WlErr
    );

    modport slave (
        input  Wordline, WriteData, SrcReg1, ReadEn1, SrcReg2, ReadEn2,
        output SrcData1, RdValid1, SrcData2, RdValid2, WlErr
    );
endinterface

// File: rtl/regfile_read_unit.sv
// 16-entry register file with one-hot wordline writes, two registered read ports,
// optional write-to-read bypass, R0 hardwired to zero and a sticky malformed-wordline flag.
module regfile_read_unit #(
    parameter int WIDTH  = 16,
    parameter bit BYPASS = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    regfile_read_unit_if.slave bus
);
    localparam int NREG = 16;

    logic [WIDTH-1:0] regs_q [NREG];
    logic [WIDTH-1:0] regs_d [NREG];
    logic [WIDTH-1:0] src_data1_q, src_data1_d;
    logic [WIDTH-1:0] src_data2_q, src_data2_d;
    logic             rd_valid1_q, rd_valid1_d;
    logic             rd_valid2_q, rd_valid2_d;
    logic             wl_err_q, wl_err_d;

    logic             wl_onehot;
    logic             wr_valid;
    logic [3:0]       wr_idx;

    // Priority: R0 reads zero, then same-edge bypass, then stored contents.
    function automatic logic [WIDTH-1:0] read_value(
        input logic [3:0]       addr,
        input logic [WIDTH-1:0] stored,
        input logic             wr_hit,
        input logic [WIDTH-1:0] wdata
    );
        if (addr == 4'd0)
            return '0;
        if (BYPASS && wr_hit)
            return wdata;
        return stored;
    endfunction

    // NOTE: combinational logic uses blocking assignments and gives every output a
    // default first, so no path can leave a variable unassigned and infer a latch.
    always_comb begin
        wr_idx = 4'd0;
        for (int i = 0; i < NREG; i++) begin
            if (bus.Wordline[i])
                wr_idx = 4'(i);
        end
        wl_onehot = (bus.Wordline != 16'd0) &&
                    ((bus.Wordline & (bus.Wordline - 16'd1)) == 16'd0);
        // Bit 0 alone selects R0, which is read-only: discard without error.
        wr_valid  = wl_onehot && !bus.Wordline[0];

        regs_d = regs_q;
        if (wr_valid)
            regs_d[wr_idx] = bus.WriteData;

        wl_err_d = wl_err_q | ((bus.Wordline != 16'd0) && !wl_onehot);

        rd_valid1_d = bus.ReadEn1;
        src_data1_d = src_data1_q;
        if (bus.ReadEn1)
            src_data1_d = read_value(bus.SrcReg1, regs_q[bus.SrcReg1],
                                     wr_valid && (wr_idx == bus.SrcReg1), bus.WriteData);

        rd_valid2_d = bus.ReadEn2;
        src_data2_d = src_data2_q;
        if (bus.ReadEn2)
            src_data2_d = read_value(bus.SrcReg2, regs_q[bus.SrcReg2],
                                     wr_valid && (wr_idx == bus.SrcReg2), bus.WriteData);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            // NOTE: the storage array is reset explicitly because registers must
            // read zero after reset; this rules out mapping it onto a RAM macro.
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            src_data1_q <= '0;
            src_data2_q <= '0;
            rd_valid1_q <= 1'b0;
            rd_valid2_q <= 1'b0;
            wl_err_q    <= 1'b0;
        end else begin
            regs_q      <= regs_d;
            src_data1_q <= src_data1_d;
            src_data2_q <= src_data2_d;
            rd_valid1_q <= rd_valid1_d;
            rd_valid2_q <= rd_valid2_d;
            wl_err_q    <= wl_err_d;
        end
    end

    assign bus.SrcData1 = src_data1_q;
    assign bus.RdValid1 = rd_valid1_q;
    assign bus.SrcData2 = src_data2_q;
    assign bus.RdValid2 = rd_valid2_q;
    assign bus.WlErr    = wl_err_q;
endmodule

// File: doc/regfile_read_unit.md
# regfile_read_unit

Read side of the 16-entry register file. Holds the 16 x 16-bit register storage and is written by the one-hot `Wordline` that the write decoder produces. Serves two independent registered read ports (SrcReg1/SrcReg2) to the decode stage, with write-to-read bypass and R0 hardwired to zero. Also flags any malformed (non-one-hot) wordline with a sticky error.

## Interface
- `WIDTH`, 16, register data width.
- `BYPASS`, 1, 1 = a same-cycle write to the register being read is forwarded to the read output; 0 = the read returns the pre-write value.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low; one clock domain only.
- `Wordline`  in  16  one-hot write select from the write decoder; all-zero = no write.
- `WriteData`  in  WIDTH  data written to the selected register.
- `SrcReg1`  in  4  read address, port 1.
- `ReadEn1`  in  1  read request, port 1.
- `SrcReg2`  in  4  read address, port 2.
- `ReadEn2`  in  1  read request, port 2.
- `SrcData1`  out  WIDTH  registered read data, port 1.
- `RdValid1`  out  1  one-cycle pulse; `SrcData1` is valid.
- `SrcData2`  out  WIDTH  registered read data, port 2.
- `RdValid2`  out  1  one-cycle pulse; `SrcData2` is valid.
- `WlErr`  out  1  sticky; set when `Wordline` has more than one bit set.

## Operation
- Storage: `reg[0..15]`, each WIDTH bits. R0 reads as 0 at all times and is never written.
- Write, evaluated at each rising edge when `rst_n`=1:
  - `Wordline`=0: no write.
  - Exactly one bit i set, i!=0: `reg[i] <= WriteData`.
  - Only bit 0 set: write is discarded; no error.
  - Two or more bits set: no register is written; `WlErr <= 1`.
- `WlErr` clears only on reset.
- Each read port p behaves identically and independently of the other:
  - `ReadEn_p`=1 at edge N: `SrcData_p` is loaded at edge N and `RdValid_p`=1 during cycle N+1.
  - `ReadEn_p`=0: `RdValid_p`=0 and `SrcData_p` holds its last value.
- Read value selection, in priority order:
  - If `SrcReg_p`=0, the value is 0.
  - Else, if `BYPASS`=1 and this edge performs a valid write to `SrcReg_p`, the value is `WriteData`.
  - Else, the value is `reg[SrcReg_p]` before the edge.
- Both ports may read the same register in the same cycle; both return identical data.
- A malformed wordline never triggers bypass.

## Timing
- Reset: `rst_n`=0 sampled at an edge clears all `reg`, `SrcData1`/`SrcData2`=0, `RdValid1`/`RdValid2`=0, and `WlErr`=0.
  - A write or read presented in the same cycle as reset is dropped.
  - A read issued the cycle before reset produces no valid pulse after reset.
- Read latency: exactly 1 cycle, from the `ReadEn` edge to `RdValid` high.
- Throughput: one read per port per cycle; back-to-back reads give `RdValid` high on consecutive cycles.
- Write latency: visible to a non-bypassed read issued at the next edge or later.
- With `BYPASS`=0, a same-edge read returns the old value.
- No combinational path from any input to any output.

## Test plan
- Reset then read: `rst_n`=0 for 2 cycles, then read R5 on both ports -> `SrcData1`=`SrcData2`=0x0000, `RdValid1`=`RdValid2`=1 for one cycle, `WlErr`=0.
- Write then read: `Wordline`=0x0008, `WriteData`=0xBEEF at edge N; `ReadEn1`, `SrcReg1`=3 at edge N+1 -> `SrcData1`=0xBEEF with `RdValid1`=1 in cycle N+2; no read pulse on port 2.
- Bypass: at one edge, `Wordline`=0x0400 with `WriteData`=0x1234, and `ReadEn2` with `SrcReg2`=10.
  - `BYPASS`=1 -> next cycle `SrcData2`=0x1234.
  - `BYPASS`=0 -> next cycle `SrcData2`=old R10 (0x0000 after reset).
- R0 protection: `Wordline`=0x0001, `WriteData`=0xFFFF; then read R0 -> `SrcData1`=0x0000, `WlErr`=0.
- Malformed wordline: load R1=0x1111 and R2=0x2222; then `Wordline`=0x0006, `WriteData`=0xAAAA.
  - Required: `WlErr`=1 next cycle and stays 1; R1 reads 0x1111, R2 reads 0x2222.
  - Then `rst_n`=0 for one edge -> `WlErr`=0.
- Reset mid-read: `ReadEn1` at edge N, `rst_n`=0 at edge N+1 -> `RdValid1`=0 and `SrcData1`=0 after edge N+1; all registers read 0 afterwards.
